prio_enc_pending: RTL and testbench

//  Parametrised N-input priority encoder with a pending-request register and a

---
 rtl/prio_enc_pending.sv | 127 ++++++++++++
 tb/tb_prio_enc_pending.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_pending.sv
// -----------------------------------------------------------------------------
// prio_enc_pending
//
// N-input priority encoder with a pending-request register and a registered
// valid/ready output stage. Requests are latched into a pending vector. The
// highest-index eligible pending bit is presented as out_idx. That bit is
// cleared when the consumer accepts it.
//
// Parameters
//   N     number of request inputs (N >= 1)
//   EDGE  0: level capture, 1: rising-edge capture of req
//   W     index width, derived from N (not overridable)
//
// Optional feature
//   IRQ_MASK_EN  when defined, adds the mask input. Masked bits still latch
//                into pend but are never granted.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   rst        in   synchronous reset, active-high
//   req        in   [N-1:0] request vector, bit i = source i
//   out_ready  in   consumer accepts out_idx this cycle
//   mask       in   [N-1:0] (IRQ_MASK_EN only) 1 = bit excluded from encoding
//   out_valid  out  out_idx holds a pending request
//   out_idx    out  [W-1:0] granted source index (higher index wins)
//   pend       out  [N-1:0] registered pending vector
//   error      out  registered "nothing pending" flag (= ~|pend)
//
// Handshake: a transfer happens on a rising edge where out_valid and out_ready
// are both 1. While out_valid=1 and out_ready=0, out_idx is held stable, even if
// a higher-priority request arrives; preemption only takes effect at the next
// load of the output stage. out_ready has no effect while out_valid=0.
// -----------------------------------------------------------------------------
module prio_enc_pending #(
  parameter int  N    = 8,
  parameter int  EDGE = 0,
  localparam int W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
`ifdef IRQ_MASK_EN
  input  logic [N-1:0] mask,
`endif
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend,
  output logic         error
);

  logic [N-1:0] req_q;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] pend_next;
  logic [N-1:0] mask_eff;
  logic [N-1:0] eligible;
  logic         accept;
  logic         load;
  logic         any_eligible;
  logic [W-1:0] top_idx;

`ifdef IRQ_MASK_EN
  assign mask_eff = mask;
`else
  assign mask_eff = '0;
`endif

  // Edge mode only sets a bit on a 0->1 transition of req, so a held request
  // produces exactly one grant.
  always_comb begin
    set_vec = req;
    if (EDGE != 0) begin
      set_vec = req & ~req_q;
    end
  end

  assign accept = out_valid & out_ready;

  // One-hot clear of the index being accepted this cycle.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < N; i++) begin
      clr_vec[i] = accept && (out_idx == W'(i));
    end
  end

  // Set wins over clear: a bit accepted and re-requested in the same cycle
  // remains pending.
  assign pend_next = (pend & ~clr_vec) | set_vec;
  assign eligible  = pend_next & ~mask_eff;

  // Highest set bit of eligible; later iterations override earlier ones.
  always_comb begin
    any_eligible = 1'b0;
    top_idx      = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) begin
        any_eligible = 1'b1;
        top_idx      = W'(i);
      end
    end
  end

  // The output stage only reloads when empty or being drained; otherwise it
  // holds, which gives the stability guarantee under back-pressure.
  assign load = !out_valid || accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      error     <= 1'b1;
    end else begin
      req_q <= req;
      pend  <= pend_next;
      error <= ~|pend_next;
      if (load) begin
        out_valid <= any_eligible;
        out_idx   <= top_idx;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_pending.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_pending
//
// Four instances share one stimulus stream:
//   d0: N=8 EDGE=0   d1: N=8 EDGE=1   d2: N=5 EDGE=0   d3: N=1 EDGE=0
// A behavioural model (bit arrays, one step per clock) predicts every output.
// Directed sequences come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_prio_enc_pending;

  localparam int NS [4] = '{8, 8, 5, 1};
  localparam int ES [4] = '{0, 1, 0, 0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d   = 1'b1;
  logic [7:0] req_d   = '0;
  logic       rdy_d   = 1'b0;
  logic [7:0] mask_d  = '0;

  logic       v0, v1, v2, v3;
  logic [2:0] i0, i1, i2;
  logic [0:0] i3;
  logic [7:0] p0, p1;
  logic [4:0] p2;
  logic [0:0] p3;
  logic       e0, e1, e2, e3;

  // ---------------- DUTs ----------------
  prio_enc_pending #(.N(8), .EDGE(0)) d0 (
    .clk(clk), .rst(rst_d), .req(req_d), .out_ready(rdy_d),
`ifdef IRQ_MASK_EN
    .mask(mask_d),
`endif
    .out_valid(v0), .out_idx(i0), .pend(p0), .error(e0));

  prio_enc_pending #(.N(8), .EDGE(1)) d1 (
    .clk(clk), .rst(rst_d), .req(req_d), .out_ready(rdy_d),
`ifdef IRQ_MASK_EN
    .mask(mask_d),
`endif
    .out_valid(v1), .out_idx(i1), .pend(p1), .error(e1));

  prio_enc_pending #(.N(5), .EDGE(0)) d2 (
    .clk(clk), .rst(rst_d), .req(req_d[4:0]), .out_ready(rdy_d),
`ifdef IRQ_MASK_EN
    .mask(mask_d[4:0]),
`endif
    .out_valid(v2), .out_idx(i2), .pend(p2), .error(e2));

  prio_enc_pending #(.N(1), .EDGE(0)) d3 (
    .clk(clk), .rst(rst_d), .req(req_d[0:0]), .out_ready(rdy_d),
`ifdef IRQ_MASK_EN
    .mask(mask_d[0:0]),
`endif
    .out_valid(v3), .out_idx(i3), .pend(p3), .error(e3));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int grants1 = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pend  [4][8];
  int m_reqq  [4][8];
  int m_valid [4];
  int m_idx   [4];
  int m_err   [4];

  function automatic int masked(input int i);
`ifdef IRQ_MASK_EN
    return int'(mask_d[i]);
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    int n;
    int acc;
    int best;
    int s;
    int nxt [8];
    for (int k = 0; k < 4; k++) begin
      n = NS[k];
      if (rst_d) begin
        for (int i = 0; i < 8; i++) begin
          m_pend[k][i] = 0;
          m_reqq[k][i] = 0;
        end
        m_valid[k] = 0;
        m_idx[k]   = 0;
        m_err[k]   = 1;
        continue;
      end
      acc = (m_valid[k] != 0 && rdy_d) ? 1 : 0;
      if (acc != 0 && k == 0) exp_q.push_back(8'(m_idx[0]));
      for (int i = 0; i < 8; i++) nxt[i] = 0;
      for (int i = 0; i < n; i++) begin
        if (ES[k] != 0) s = (req_d[i] && m_reqq[k][i] == 0) ? 1 : 0;
        else            s = int'(req_d[i]);
        if (s != 0) nxt[i] = 1;
        else if (m_pend[k][i] != 0 && !(acc != 0 && m_idx[k] == i)) nxt[i] = 1;
      end
      if (m_valid[k] == 0 || acc != 0) begin
        best = -1;
        for (int i = 0; i < n; i++)
          if (nxt[i] != 0 && masked(i) == 0) best = i;
        m_valid[k] = (best >= 0) ? 1 : 0;
        m_idx[k]   = (best >= 0) ? best : 0;
      end
      m_err[k] = 1;
      for (int i = 0; i < n; i++) begin
        if (nxt[i] != 0) m_err[k] = 0;
        m_pend[k][i] = nxt[i];
        m_reqq[k][i] = int'(req_d[i]);
      end
    end
  endtask

  function automatic logic [31:0] m_pend_vec(input int k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NS[k]; i++) if (m_pend[k][i] != 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic dut_out(input int k, output logic [31:0] v, output logic [31:0] ix,
                         output logic [31:0] p, output logic [31:0] e);
    case (k)
      0:       begin v = 32'(v0); ix = 32'(i0); p = 32'(p0); e = 32'(e0); end
      1:       begin v = 32'(v1); ix = 32'(i1); p = 32'(p1); e = 32'(e1); end
      2:       begin v = 32'(v2); ix = 32'(i2); p = 32'(p2); e = 32'(e2); end
      default: begin v = 32'(v3); ix = 32'(i3); p = 32'(p3); e = 32'(e3); end
    endcase
  endtask

  task automatic check_all();
    logic [31:0] v, ix, p, e;
    for (int k = 0; k < 4; k++) begin
      dut_out(k, v, ix, p, e);
      check_eq($sformatf("d%0d_valid", k), v, 32'(m_valid[k]));
      check_eq($sformatf("d%0d_idx", k),   ix, 32'(m_idx[k]));
      check_eq($sformatf("d%0d_pend", k),  p, m_pend_vec(k));
      check_eq($sformatf("d%0d_error", k), e, 32'(m_err[k]));
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs, record handshakes seen before the edge, step the model at
  // the edge, then compare everything 1 time unit later.
  task automatic tick(input logic [7:0] r, input logic rdy, input logic rs);
    req_d = r;
    rdy_d = rdy;
    rst_d = rs;
    #1;
    if (!rst_d && v0 && rdy_d) got_q.push_back(8'(i0));
    if (!rst_d && v1 && rdy_d) grants1++;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);

    // reset with all requests high
    tick(8'hFF, 1'b0, 1'b1);
    tick(8'hFF, 1'b1, 1'b1);
    check_eq("rst_valid", 32'(v0), 32'd0);
    check_eq("rst_idx",   32'(i0), 32'd0);
    check_eq("rst_pend",  32'(p0), 32'd0);
    check_eq("rst_error", 32'(e0), 32'd1);

    // two-bit burst drained back to back
    tick(8'hA0, 1'b1, 1'b0);
    check_eq("burst_idx7",  32'(i0), 32'd7);
    check_eq("burst_pendA0", 32'(p0), 32'hA0);
    tick(8'h00, 1'b1, 1'b0);
    check_eq("burst_idx5",  32'(i0), 32'd5);
    check_eq("burst_pend20", 32'(p0), 32'h20);
    tick(8'h00, 1'b1, 1'b0);
    check_eq("burst_empty_valid", 32'(v0), 32'd0);
    check_eq("burst_empty_error", 32'(e0), 32'd1);
    check_eq("burst_pend00", 32'(p0), 32'h00);

    // stall: higher priority arrives while idx 2 is held
    tick(8'h04, 1'b0, 1'b0);
    tick(8'h40, 1'b0, 1'b0);
    check_eq("stall_idx2_a", 32'(i0), 32'd2);
    tick(8'h00, 1'b0, 1'b0);
    check_eq("stall_idx2_b", 32'(i0), 32'd2);
    check_eq("stall_pend44", 32'(p0), 32'h44);
    tick(8'h00, 1'b1, 1'b0);
    check_eq("stall_idx6", 32'(i0), 32'd6);
    tick(8'h00, 1'b1, 1'b0);

    // accept and re-request in the same cycle
    tick(8'h08, 1'b0, 1'b0);
    tick(8'h08, 1'b1, 1'b0);
    check_eq("rereq_pend3", 32'(p0[3]), 32'd1);
    check_eq("rereq_idx3",  32'(i0), 32'd3);
    check_eq("rereq_valid", 32'(v0), 32'd1);

    // rising-edge capture on d1: held request gives one grant
    tick(8'h00, 1'b0, 1'b1);
    grants1 = 0;
    for (int c = 0; c < 5; c++) tick(8'h10, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) tick(8'h00, 1'b1, 1'b0);
    check_eq("edge_one_grant", 32'(grants1), 32'd1);
    tick(8'h10, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) tick(8'h00, 1'b1, 1'b0);
    check_eq("edge_two_grants", 32'(grants1), 32'd2);

`ifdef IRQ_MASK_EN
    // masked bit latches but is not granted until unmasked
    tick(8'h00, 1'b0, 1'b1);
    mask_d = 8'h80;
    tick(8'h81, 1'b1, 1'b0);
    check_eq("mask_idx0", 32'(i0), 32'd0);
    tick(8'h00, 1'b1, 1'b0);
    check_eq("mask_pend80", 32'(p0), 32'h80);
    check_eq("mask_valid0", 32'(v0), 32'd0);
    mask_d = 8'h00;
    tick(8'h00, 1'b0, 1'b0);
    check_eq("unmask_valid", 32'(v0), 32'd1);
    check_eq("unmask_idx7",  32'(i0), 32'd7);
    tick(8'h00, 1'b1, 1'b0);
`endif

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
`ifdef IRQ_MASK_EN
      mask_d = 8'($urandom & $urandom & $urandom);
`endif
      tick(8'($urandom & $urandom),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 199) == 0));
    end

    // handshake order seen on d0 against the model's accepted indices
    check_eq("grant_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      if (got_q[j] !== exp_q[j]) begin
        check_eq($sformatf("grant_seq_%0d", j), 32'(got_q[j]), 32'(exp_q[j]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
